// File: rtl/tmp75_i2c_target_if.sv
// Open-drain I2C bus seen by the TMP75 target: sampled SCL/SDA plus the SDA pull-down enable.
interface tmp75_i2c_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/tmp75_i2c_target.sv
// I2C target emulating a TMP75: pointer write, 2-byte temperature read, config register read/write.
module tmp75_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'b1001000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0] CFG_RST     = 8'h00
) (
    input  logic                clk,
    input  logic                rst,
    tmp75_i2c_target_if.slave   bus,
    input  logic [11:0]         temp_in,
    output logic [7:0]          cfg_reg,
    output logic [1:0]          ptr_reg,
    output logic                rd_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_MACK, S_WAIT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic [SYNC_STAGES:0]   vld;
    logic                   scl_s, sda_s, ev_en;
    logic                   scl_rise, scl_fall, start_ev, stop_ev;
    logic                   sda_oe_r, rw, byte_idx, mack_ok;
    logic [3:0]             bit_cnt;
    logic [7:0]             sh, tx, first_byte, next_byte;
    logic [11:0]            snap;

    function automatic logic [7:0] rd_byte(input logic [1:0] p, input logic idx,
                                           input logic [11:0] t, input logic [7:0] c);
        case (p)
            2'd0:    return idx ? {t[3:0], 4'h0} : t[11:4];
            2'd1:    return c;
            default: return 8'h00;
        endcase
    endfunction

    // Synchronisers reset to the idle-bus level; vld masks events until the history flop holds real samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            vld      <= '0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
            vld      <= {vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    always_comb begin
        scl_s      = scl_sync[SYNC_STAGES-1];
        sda_s      = sda_sync[SYNC_STAGES-1];
        ev_en      = vld[SYNC_STAGES];
        scl_rise   = ev_en & scl_s & ~scl_d;
        scl_fall   = ev_en & ~scl_s & scl_d;
        start_ev   = ev_en & scl_s & scl_d & sda_d & ~sda_s;
        stop_ev    = ev_en & scl_s & scl_d & ~sda_d & sda_s;
        first_byte = rd_byte(ptr_reg, 1'b0, temp_in, cfg_reg);
        next_byte  = rd_byte(ptr_reg, byte_idx, snap, cfg_reg);
    end

    assign bus.sda_oe = sda_oe_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            sda_oe_r <= 1'b0;
            cfg_reg  <= CFG_RST;
            ptr_reg  <= 2'd0;
            rd_done  <= 1'b0;
            snap     <= '0;
            sh       <= '0;
            tx       <= '0;
            bit_cnt  <= '0;
            rw       <= 1'b0;
            byte_idx <= 1'b0;
            mack_ok  <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            if (stop_ev) begin
                state    <= S_IDLE;
                sda_oe_r <= 1'b0;
            end else if (start_ev) begin
                state    <= S_ADDR;
                bit_cnt  <= '0;
                sda_oe_r <= 1'b0;
            end else begin
                if (scl_rise && (state == S_ADDR || state == S_PTR || state == S_WDATA)) begin
                    sh      <= {sh[6:0], sda_s};
                    bit_cnt <= bit_cnt + 4'd1;
                end
                case (state)
                    S_ADDR: if (scl_fall && bit_cnt == 4'd8) begin
                        if (sh[7:1] == DEV_ADDR) begin
                            sda_oe_r <= 1'b1;
                            rw       <= sh[0];
                            state    <= S_ADDR_ACK;
                        end else begin
                            state    <= S_WAIT;
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        if (!rw) begin
                            sda_oe_r <= 1'b0;
                            bit_cnt  <= '0;
                            state    <= S_PTR;
                        end else begin
                            snap     <= temp_in;
                            byte_idx <= 1'b0;
                            sda_oe_r <= ~first_byte[7];
                            tx       <= {first_byte[6:0], 1'b0};
                            bit_cnt  <= 4'd1;
                            state    <= S_RDATA;
                        end
                    end
                    S_PTR: if (scl_fall && bit_cnt == 4'd8) begin
                        ptr_reg  <= sh[1:0];
                        sda_oe_r <= 1'b1;
                        state    <= S_PTR_ACK;
                    end
                    S_WDATA: if (scl_fall && bit_cnt == 4'd8) begin
                        if (ptr_reg == 2'd1) cfg_reg <= sh;
                        sda_oe_r <= 1'b1;
                        state    <= S_WDATA_ACK;
                    end
                    S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        sda_oe_r <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= S_WDATA;
                    end
                    S_RDATA: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_r <= 1'b0;
                            mack_ok  <= 1'b0;
                            state    <= S_MACK;
                        end else begin
                            sda_oe_r <= ~tx[7];
                            tx       <= {tx[6:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end
                    S_MACK: begin
                        if (scl_rise) begin
                            if (ptr_reg == 2'd0 && byte_idx) rd_done <= 1'b1;
                            if (!sda_s) begin
                                mack_ok  <= 1'b1;
                                byte_idx <= ~byte_idx;
                            end else begin
                                state    <= S_WAIT;
                            end
                        end else if (scl_fall && mack_ok) begin
                            sda_oe_r <= ~next_byte[7];
                            tx       <= {next_byte[6:0], 1'b0};
                            bit_cnt  <= 4'd1;
                            state    <= S_RDATA;
                        end
                    end
                    default: sda_oe_r <= 1'b0;
                endcase
            end
        end
    end

endmodule
